m68k_bus_master: RTL and testbench
==================================

// Module: m68k_bus_master
// PURPOSE
//  68000-style bus initiator for DMA/debug engines. Requests the bus via BR/BG/BGACK, runs
//  byte/word read and write cycles (AS/UDS/LDS/RW), and waits for DTACK from any responder
//  (DRAM controller, ROM/IO decode). Returns read data or a timeout error on a simple
//  valid/ready request/response interface. Sits beside the CPU on the shared bus.
// PARAMETERS
//  TIMEOUT_CYCLES  64  CLK cycles in WAIT_ACK before the cycle is aborted with RSP_ERR=1
//  SYNC_STAGES     2   flip-flop depth for BG, DTACK, AS_IN synchronisers (>=2)
// PORTS
//  CLK         in   1   system clock
//  RST         in   1   synchronous reset, active-high
//  REQ_VALID   in   1   request present; all REQ_* stable while REQ_VALID && !REQ_READY
//  REQ_READY   out  1   request accepted this cycle
//  REQ_ADDR    in   23  word address [23:1]
//  REQ_RW      in   1   1=read, 0=write
//  REQ_UDS     in   1   active-low upper-byte enable
//  REQ_LDS     in   1   active-low lower-byte enable
//  REQ_WDATA   in   16  write data
//  REQ_HOLD    in   1   keep bus ownership after this cycle if another request follows
//  RSP_VALID   out  1   one-cycle pulse: cycle finished
//  RSP_RDATA   out  16  read data (valid with RSP_VALID, read cycles only)
//  RSP_ERR     out  1   1 = DTACK timeout
//  BR          out  1   bus request, active-low
//  BG          in   1   bus grant, active-low (async)
//  BGACK       out  1   bus grant acknowledge, active-low
//  AS_IN       in   1   bus AS as seen on the bus (async), used for bus-free detection
//  DTACK       in   1   data acknowledge, active-low (async)
//  BUS_OE      out  1   1 = drive ADDR_OUT/AS/UDS/LDS/RW (+DATA_OUT on writes) onto bus
//  AS          out  1   address strobe, active-low
//  UDS, LDS    out  1   data strobes, active-low
//  RW          out  1   1=read, 0=write
//  ADDR_OUT    out  23  bus address [23:1]
//  DATA_OUT    out  16  bus write data
//  DATA_IN     in   16  bus read data
// BEHAVIOUR
//  Reset values: BR=BGACK=AS=UDS=LDS=RW=1, BUS_OE=0, REQ_READY=0, RSP_VALID=0, RSP_ERR=0,
//   ADDR_OUT=0, DATA_OUT=0, RSP_RDATA=0; state=IDLE, timeout counter=0. RST mid-cycle
//   drops all strobes and BGACK next edge; pending request not responded.
//  Synchronised (SYNC_STAGES) BG_s, DTACK_s, AS_s used for all decisions.
//  States:
//   IDLE:     REQ_VALID -> BR=0, goto ARB.
//   ARB:      wait BG_s=0 && AS_s=1 && DTACK_s=1 -> BGACK=0, BR=1, goto ADDR.
//   ADDR:     REQ_READY=1 (1 cycle); latch ADDR_OUT, RW=REQ_RW, DATA_OUT; BUS_OE=1; -> STROBE.
//   STROBE:   AS=0; UDS/LDS=latched enables; counter=0; -> WAIT_ACK.
//   WAIT_ACK: counter++ each cycle. DTACK_s=0 -> LATCH. counter==TIMEOUT_CYCLES-1 and
//             DTACK_s=1 -> RSP_ERR latched 1, -> END. DTACK_s=0 wins if same cycle.
//   LATCH:    RSP_RDATA<=DATA_IN (read; unchanged on write) -> END.
//   END:      AS=UDS=LDS=1, RW=1, RSP_VALID=1 (1 cycle); -> DTWAIT.
//   DTWAIT:   wait DTACK_s=1 (responder released; no timeout); then if REQ_VALID && REQ_HOLD
//             -> ADDR (bus kept), else BUS_OE=0, BGACK=1 -> IDLE.
//  Timing: acquired bus, first read: REQ_READY 1 cycle after ARB exit; AS low 1 cycle later;
//   RSP_VALID exactly 3 cycles after DTACK_s falls (LATCH, END, pulse).
//  RSP_ERR cleared when next cycle enters STROBE; REQ_UDS=REQ_LDS=1 still runs a cycle (AS only).
//  BR never low while BGACK low; BGACK low only while owning; BUS_OE=0 whenever BGACK=1.
// TESTING
//  1 word read: DTACK low 4 cycles after AS, DATA_IN=16'hBEEF -> RSP_VALID, RSP_RDATA=BEEF, ERR=0.
//  2 byte write addr 23'h000100, UDS=0 LDS=1, WDATA=16'h12xx -> AS=0 UDS=0 LDS=1 RW=0, DATA_OUT stable.
//  3 BG held high 20 cycles -> BR=0, BGACK=1, BUS_OE=0, no strobe; BG low with AS_IN low -> wait for AS_IN=1.
//  4 DTACK never asserted, TIMEOUT_CYCLES=64 -> RSP_VALID with RSP_ERR=1 after 64 WAIT_ACK cycles, AS=1.
//  5 two requests REQ_HOLD=1 -> second ADDR without BR/BGACK toggling; ends with BGACK=1, BUS_OE=0.
//  6 RST asserted in WAIT_ACK -> next edge AS=UDS=LDS=BGACK=BR=1, BUS_OE=0, no RSP_VALID.

Source files
------------

// File: rtl/m68k_bus_master.sv
// m68k_bus_master
//   68000-style bus initiator for DMA/debug engines. Arbitrates for the shared
//   bus with BR/BG/BGACK and runs one byte/word read or write per accepted
//   request using AS/UDS/LDS/RW. It then waits for DTACK from whichever
//   responder decodes the address. Each request gets one response pulse that
//   carries either the read data or a DTACK-timeout error.
//
// Ports
//   CLK, RST              clock, synchronous active-high reset
//   REQ_VALID/REQ_READY   request handshake; REQ_* is held until REQ_READY
//   REQ_ADDR[23:1]        word address
//   REQ_RW                1 = read, 0 = write
//   REQ_UDS, REQ_LDS      active-low byte enables
//   REQ_WDATA             write data
//   REQ_HOLD              keep the bus for a back-to-back follow-on request
//   RSP_VALID             one-cycle completion pulse
//   RSP_RDATA             read data (read cycles)
//   RSP_ERR               DTACK timeout
//   BR, BG, BGACK         bus arbitration (active-low; BG is asynchronous)
//   AS_IN, DTACK          bus AS and DTACK as seen on the bus (asynchronous)
//   BUS_OE                enable for the bus drivers of the outputs below
//   AS, UDS, LDS, RW      bus strobes (active-low) and direction
//   ADDR_OUT, DATA_OUT    bus address and write data
//   DATA_IN               bus read data

module m68k_bus_master #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [23:1] REQ_ADDR,
  input  logic        REQ_RW,
  input  logic        REQ_UDS,
  input  logic        REQ_LDS,
  input  logic [15:0] REQ_WDATA,
  input  logic        REQ_HOLD,
  output logic        RSP_VALID,
  output logic [15:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic        BR,
  input  logic        BG,
  output logic        BGACK,
  input  logic        AS_IN,
  input  logic        DTACK,
  output logic        BUS_OE,
  output logic        AS,
  output logic        UDS,
  output logic        LDS,
  output logic        RW,
  output logic [23:1] ADDR_OUT,
  output logic [15:0] DATA_OUT,
  input  logic [15:0] DATA_IN
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_ADDR, S_STROBE, S_WAIT_ACK, S_LATCH, S_END, S_DTWAIT
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               uds_q, lds_q;

  // Synchronisers. They reset to the inactive (high) level, so a fresh reset
  // never shows a phantom grant or acknowledge.
  logic [SYNC_STAGES-1:0] bg_sr, dtack_sr, as_sr;
  logic                   bg_s, dtack_s, as_s;

  always_ff @(posedge CLK) begin
    if (RST) begin
      bg_sr    <= '1;
      dtack_sr <= '1;
      as_sr    <= '1;
    end else begin
      bg_sr    <= {bg_sr[SYNC_STAGES-2:0], BG};
      dtack_sr <= {dtack_sr[SYNC_STAGES-2:0], DTACK};
      as_sr    <= {as_sr[SYNC_STAGES-2:0], AS_IN};
    end
  end

  assign bg_s    = bg_sr[SYNC_STAGES-1];
  assign dtack_s = dtack_sr[SYNC_STAGES-1];
  assign as_s    = as_sr[SYNC_STAGES-1];

  // Two ways into the address phase: a fresh grant once the previous master
  // has fully left the bus (AS and DTACK both released), or a held bus with a
  // follow-on request once our own responder has released DTACK.
  logic grant_ok, hold_next, start_addr;
  assign grant_ok   = (state == S_ARB) && !bg_s && as_s && dtack_s;
  assign hold_next  = (state == S_DTWAIT) && dtack_s && REQ_VALID && REQ_HOLD;
  assign start_addr = grant_ok || hold_next;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      uds_q     <= 1'b1;
      lds_q     <= 1'b1;
      REQ_READY <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_ERR   <= 1'b0;
      RSP_RDATA <= '0;
      BR        <= 1'b1;
      BGACK     <= 1'b1;
      BUS_OE    <= 1'b0;
      AS        <= 1'b1;
      UDS       <= 1'b1;
      LDS       <= 1'b1;
      RW        <= 1'b1;
      ADDR_OUT  <= '0;
      DATA_OUT  <= '0;
    end else begin
      REQ_READY <= 1'b0;
      RSP_VALID <= 1'b0;

      case (state)
        S_IDLE: if (REQ_VALID) begin
          BR    <= 1'b0;
          state <= S_ARB;
        end
        S_ARB: begin
          // exit is handled by start_addr below
        end
        S_ADDR: begin
          // The address is already stable for one cycle. Now strobe.
          AS      <= 1'b0;
          UDS     <= uds_q;
          LDS     <= lds_q;
          RSP_ERR <= 1'b0;
          cnt     <= '0;
          state   <= S_STROBE;
        end
        S_STROBE: state <= S_WAIT_ACK;
        S_WAIT_ACK: begin
          cnt <= cnt + 1'b1;
          // An acknowledge arriving in the final cycle still counts.
          if (!dtack_s)
            state <= S_LATCH;
          else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            RSP_ERR <= 1'b1;
            state   <= S_END;
          end
        end
        S_LATCH: begin
          if (RW) RSP_RDATA <= DATA_IN;
          state <= S_END;
        end
        S_END: begin
          AS        <= 1'b1;
          UDS       <= 1'b1;
          LDS       <= 1'b1;
          RW        <= 1'b1;
          RSP_VALID <= 1'b1;
          state     <= S_DTWAIT;
        end
        S_DTWAIT: if (dtack_s && !hold_next) begin
          BUS_OE <= 1'b0;
          BGACK  <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (start_addr) begin
        BR        <= 1'b1;
        BGACK     <= 1'b0;
        BUS_OE    <= 1'b1;
        REQ_READY <= 1'b1;
        ADDR_OUT  <= REQ_ADDR;
        RW        <= REQ_RW;
        DATA_OUT  <= REQ_WDATA;
        uds_q     <= REQ_UDS;
        lds_q     <= REQ_LDS;
        state     <= S_ADDR;
      end
    end
  end

endmodule

// File: tb/tb_m68k_bus_master.sv
// Self-checking bench for m68k_bus_master. A behavioural responder answers bus
// cycles with DTACK after a programmable delay. A scoreboard queue holds the
// expected response for every accepted request.

module tb_m68k_bus_master;
  localparam int TO = 64;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_VALID, REQ_READY, REQ_RW, REQ_UDS, REQ_LDS, REQ_HOLD;
  logic [23:1] REQ_ADDR, ADDR_OUT;
  logic [15:0] REQ_WDATA, RSP_RDATA, DATA_OUT, DATA_IN;
  logic        RSP_VALID, RSP_ERR, BR, BG, BGACK, AS_IN, DTACK, BUS_OE, AS, UDS, LDS, RW;

  always #5 CLK = ~CLK;

  m68k_bus_master #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR), .REQ_RW(REQ_RW),
    .REQ_UDS(REQ_UDS), .REQ_LDS(REQ_LDS), .REQ_WDATA(REQ_WDATA), .REQ_HOLD(REQ_HOLD),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .BR(BR), .BG(BG), .BGACK(BGACK), .AS_IN(AS_IN), .DTACK(DTACK), .BUS_OE(BUS_OE),
    .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW), .ADDR_OUT(ADDR_OUT), .DATA_OUT(DATA_OUT),
    .DATA_IN(DATA_IN)
  );

  typedef struct {
    logic [23:1] addr;
    logic        rw, uds, lds;
    logic [15:0] wdata;
    logic        hold;
    logic        dt_en;     // responder acknowledges at all
    int          dt_delay;  // cycles from AS low to DTACK low
    logic [15:0] rdata;     // responder read data
    logic        exp_err;
    logic [15:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        is_read;
    logic        err;
    logic [15:0] rdata;
    logic [15:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t tbl[8];
  vec_t hv;
  vec_t hv2;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;
  int rsp_cnt  = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Responder: DTACK follows AS low by dt_delay cycles and is released when AS rises.
  logic        dt_en = 1'b0;
  int          dt_delay = 0;
  logic [15:0] dt_rdata = 16'h0;
  int          as_cnt = 0;
  int          as_cyc = 0;
  int          dt_cyc = 0;

  initial begin
    DTACK   = 1'b1;
    DATA_IN = 16'h5A5A;
    forever begin
      @(negedge CLK);
      if (AS === 1'b0 && BUS_OE === 1'b1) begin
        as_cnt++;
        if (as_cnt == 1) as_cyc = cyc;
        if (dt_en && as_cnt == dt_delay + 1) begin
          DTACK   = 1'b0;
          DATA_IN = dt_rdata;
          dt_cyc  = cyc;
        end
      end else begin
        as_cnt  = 0;
        DTACK   = 1'b1;
        DATA_IN = 16'h5A5A;
      end
    end
  end

  // Scoreboard and protocol monitor.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST === 1'b0) begin
        if (BGACK === 1'b1 && BUS_OE !== 1'b0) chk("oe_without_bgack", BUS_OE, 0);
        if (BGACK === 1'b0 && BR !== 1'b1) chk("br_while_owner", BR, 1);
      end
      if (RSP_VALID === 1'b1) begin
        rsp_cnt++;
        if (exp_q.size() == 0) chk("unexpected_rsp", RSP_VALID, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("rsp_err", RSP_ERR, mon_e.err);
          chk("rsp_as_released", AS, 1);
          if (mon_e.is_read && !mon_e.err) chk("rsp_rdata", RSP_RDATA, mon_e.rdata);
          if (!mon_e.is_read) chk("wdata_held", DATA_OUT, mon_e.wdata);
          if (mon_e.err) chk("timeout_latency", cyc - as_cyc, TO + 2);
          else           chk("ack_latency", cyc - dt_cyc, 5);
        end
      end
    end
  end

  task automatic drive_req(input vec_t v);
    REQ_ADDR  = v.addr;
    REQ_RW    = v.rw;
    REQ_UDS   = v.uds;
    REQ_LDS   = v.lds;
    REQ_WDATA = v.wdata;
    REQ_HOLD  = v.hold;
    REQ_VALID = 1'b1;
  endtask

  // Waits for acceptance, checks address and strobe phases, arms the responder.
  task automatic finish_req(input vec_t v, input logic hold_chk, input logic push);
    int   n = 0;
    int   viol = 0;
    logic seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge CLK);
      n++;
      if (hold_chk && (BGACK !== 1'b0 || BR !== 1'b1 || BUS_OE !== 1'b1)) viol++;
      if (REQ_READY === 1'b1) seen = 1'b1;
    end
    chk("req_ready_seen", seen, 1);
    if (hold_chk) chk("hold_bus_kept", viol, 0);
    if (!seen) begin
      REQ_VALID = 1'b0;
      return;
    end
    chk("addr_bgack", BGACK, 0);
    chk("addr_br", BR, 1);
    chk("addr_oe", BUS_OE, 1);
    chk("addr_out", ADDR_OUT, v.addr);
    chk("addr_rw", RW, v.rw);
    chk("addr_as_idle", AS, 1);
    dt_en    = v.dt_en;
    dt_delay = v.dt_delay;
    dt_rdata = v.rdata;
    if (push) exp_q.push_back('{v.rw, v.exp_err, v.exp_rdata, v.wdata});
    @(negedge CLK);
    REQ_VALID = 1'b0;
    chk("strobe_as", AS, 0);
    chk("strobe_uds", UDS, v.uds);
    chk("strobe_lds", LDS, v.lds);
    chk("strobe_rw", RW, v.rw);
    chk("strobe_ready_drop", REQ_READY, 0);
    chk("strobe_err_clr", RSP_ERR, 0);
    if (!v.rw) chk("strobe_data_out", DATA_OUT, v.wdata);
  endtask

  task automatic wait_release();
    int n = 0;
    while ((exp_q.size() != 0 || BGACK !== 1'b1) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk("rel_bgack", BGACK, 1);
    chk("rel_oe", BUS_OE, 0);
    chk("rel_br", BR, 1);
    chk("rel_as", AS, 1);
    chk("rel_pending", exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int viol;
    int rsp_before;
    RST = 1'b1; REQ_VALID = 1'b0; REQ_ADDR = '0; REQ_RW = 1'b1; REQ_UDS = 1'b1; REQ_LDS = 1'b1;
    REQ_WDATA = '0; REQ_HOLD = 1'b0; BG = 1'b0; AS_IN = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_br", BR, 1);       chk("rst_bgack", BGACK, 1); chk("rst_as", AS, 1);
    chk("rst_uds", UDS, 1);     chk("rst_lds", LDS, 1);     chk("rst_rw", RW, 1);
    chk("rst_oe", BUS_OE, 0);   chk("rst_ready", REQ_READY, 0);
    chk("rst_rspv", RSP_VALID, 0); chk("rst_err", RSP_ERR, 0);
    chk("rst_addr", ADDR_OUT, 0);  chk("rst_dout", DATA_OUT, 0); chk("rst_rdata", RSP_RDATA, 0);
    RST = 1'b0;
    @(negedge CLK);

    //          addr        rw    uds   lds   wdata     hold  dt_en dly rdata     err   exp_rdata
    tbl[0] = '{23'h012345, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 4,  16'hBEEF, 1'b0, 16'hBEEF};
    tbl[1] = '{23'h000100, 1'b0, 1'b0, 1'b1, 16'h12A5, 1'b0, 1'b1, 2,  16'h0000, 1'b0, 16'h0000};
    tbl[2] = '{23'h7FFFFF, 1'b0, 1'b1, 1'b0, 16'h0034, 1'b0, 1'b1, 0,  16'h0000, 1'b0, 16'h0000};
    tbl[3] = '{23'h000000, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 3,  16'h0F0F, 1'b0, 16'h0F0F};
    tbl[4] = '{23'h055555, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 0,  16'h0000, 1'b1, 16'h0000};
    tbl[5] = '{23'h02AAAA, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 62, 16'hA55A, 1'b0, 16'hA55A};
    tbl[6] = '{23'h000300, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 63, 16'h1234, 1'b1, 16'h0000};
    tbl[7] = '{23'h400000, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1,  16'hC3C3, 1'b0, 16'hC3C3};

    for (int i = 0; i < 8; i++) begin
      drive_req(tbl[i]);
      finish_req(tbl[i], 1'b0, 1'b1);
      wait_release();
      @(negedge CLK);
    end

    // Grant withheld, then granted while another master still drives AS.
    BG = 1'b1;
    repeat (3) @(negedge CLK);
    hv = '{23'h0ABCDE, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 2, 16'h7E57, 1'b0, 16'h7E57};
    drive_req(hv);
    viol = 0;
    repeat (20) begin
      @(negedge CLK);
      if (BR !== 1'b0 || BGACK !== 1'b1 || BUS_OE !== 1'b0 || AS !== 1'b1 || REQ_READY !== 1'b0) viol++;
    end
    chk("nogrant_quiet", viol, 0);
    chk("nogrant_br", BR, 0);
    AS_IN = 1'b0;
    BG    = 1'b0;
    viol  = 0;
    repeat (10) begin
      @(negedge CLK);
      if (BGACK !== 1'b1 || BUS_OE !== 1'b0 || REQ_READY !== 1'b0) viol++;
    end
    chk("busy_bus_wait", viol, 0);
    AS_IN = 1'b1;
    finish_req(hv, 1'b0, 1'b1);
    wait_release();
    @(negedge CLK);

    // Two back-to-back requests on one bus tenure.
    hv  = '{23'h000200, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1, 16'h1111, 1'b0, 16'h1111};
    hv2 = '{23'h000201, 1'b0, 1'b0, 1'b0, 16'hCAFE, 1'b1, 1'b1, 2, 16'h0000, 1'b0, 16'h0000};
    drive_req(hv);
    finish_req(hv, 1'b0, 1'b1);
    drive_req(hv2);
    finish_req(hv2, 1'b1, 1'b1);
    wait_release();
    @(negedge CLK);

    // Reset in the middle of WAIT_ACK: bus released at once, no response.
    hv = '{23'h001000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 16'h0000, 1'b0, 16'h0000};
    rsp_before = rsp_cnt;
    drive_req(hv);
    finish_req(hv, 1'b0, 1'b0);
    repeat (5) @(negedge CLK);
    chk("pre_rst_as", AS, 0);
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_rst_as", AS, 1);   chk("mid_rst_uds", UDS, 1); chk("mid_rst_lds", LDS, 1);
    chk("mid_rst_bgack", BGACK, 1); chk("mid_rst_br", BR, 1);
    chk("mid_rst_oe", BUS_OE, 0);   chk("mid_rst_rspv", RSP_VALID, 0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (80) @(negedge CLK);
    chk("mid_rst_no_rsp", rsp_cnt - rsp_before, 0);
    chk("mid_rst_idle_bgack", BGACK, 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
